// File: rtl/xor_sched_pkg.sv
// rtl/xor_sched_pkg.sv - shared types and width helpers for the NAND-XOR scheduler
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_W    = 8;

  // Index width that never collapses to zero bits for tiny parameter values.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CNT_W = idx_width(DEF_W);
  localparam int DEF_PTR_W = idx_width(DEF_NREQ);

endpackage

// File: rtl/xor_share_sched_nand_xor2.sv
// rtl/xor_share_sched_nand_xor2.sv - two-input XOR built from four NAND gates
module nand_xor2 (
  input  logic a,
  input  logic b,
  output logic x
);

  logic w_n1;
  logic w_n2;
  logic w_n3;

  assign w_n1 = ~(a & b);
  assign w_n2 = ~(a & w_n1);
  assign w_n3 = ~(b & w_n1);
  assign x    = ~(w_n2 & w_n3);

endmodule

// File: rtl/xor_share_sched.sv
// rtl/xor_share_sched.sv - round-robin bit-serial sharing of one NAND-XOR cell
// Optional XOR_PARITY_OUT_EN adds a registered parity output of each result.
module xor_share_sched
  import xor_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result
`ifdef XOR_PARITY_OUT_EN
  ,
  output logic              parity
`endif
);

  localparam int CNT_W = idx_width(W);
  localparam int PTR_W = idx_width(NREQ);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_gidx;
  logic [PTR_W-1:0] w_pick;
  logic             w_any;
  logic [NREQ-1:0]  w_rot;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_res_sh;
  logic             w_cell;

  nand_xor2 u_cell (
    .a (r_a_sh[0]),
    .b (r_b_sh[0]),
    .x (w_cell)
  );

  // Rotate requests so bit 0 is the current round-robin head; lowest set bit wins.
  assign w_rot = NREQ'({req, req} >> r_rr_ptr);

  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any  = 1'b1;
        w_pick = PTR_W'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  assign w_last = (r_cnt == CNT_W'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_cnt    <= '0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      gnt      <= '0;
      done     <= '0;
      result   <= '0;
    end else begin
      done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a_sh <= a_in[int'(w_pick)*W +: W];
            r_b_sh <= b_in[int'(w_pick)*W +: W];
            r_cnt  <= '0;
            r_gidx <= w_pick;
            gnt    <= NREQ'(1) << w_pick;
          end
        end
        SHIFT: begin
          r_res_sh <= {w_cell, r_res_sh[W-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          result   <= r_res_sh;
          done     <= gnt;
          gnt      <= '0;
          r_rr_ptr <= (r_gidx == PTR_W'(NREQ - 1)) ? '0 : r_gidx + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef XOR_PARITY_OUT_EN
  logic r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= 1'b0;
      parity <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) r_acc <= 1'b0;
      else if (r_state == SHIFT)    r_acc <= r_acc ^ w_cell;
      if (r_state == DONE)          parity <= r_acc;
    end
  end
`endif

endmodule

// File: tb/tb_xor_share_sched.sv
// tb/tb_xor_share_sched.sv - directed self-checking bench for xor_share_sched
module tb_xor_share_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  done;
  logic [7:0]  result;
`ifdef XOR_PARITY_OUT_EN
  logic        parity;
`endif

  int n_run;
  int n_fail;

  xor_share_sched #(.NREQ(4), .W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef XOR_PARITY_OUT_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int idx, output int cyc,
                           output logic [3:0] gseen, output int gcyc);
    idx   = -1;
    cyc   = 0;
    gseen = '0;
    gcyc  = 0;
    while (cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done != 4'b0) begin
        chk("done_onehot", 32'($countones(done)), 32'd1);
        for (int k = 0; k < 4; k++) if (done[k]) idx = k;
        break;
      end
      gseen |= gnt;
      if (gnt != 4'b0) gcyc++;
    end
    if (idx < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int         idx;
  int         cyc;
  int         gcyc;
  logic [3:0] gseen;
  int         exp_ord [4];
  logic [7:0] exp_res [4];
  int         exp_cyc [4];

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    req    = 4'h0;
    a_in   = {8'h0F, 8'h12, 8'hFF, 8'hA5};
    b_in   = {8'hF0, 8'h34, 8'hFF, 8'h3C};

    // Reset values while every requester is asking.
    #3;
    rst_n = 1'b0;
    req   = 4'hF;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
`ifdef XOR_PARITY_OUT_EN
    chk("rst_parity", 32'(parity), 32'h0);
`endif

    // All requesting from reset: service order 0,1,2,3 every W+2 cycles.
    start(4'hF);
    chk("all_first_gnt", 32'(gnt), 32'h1);
    exp_ord = '{0, 1, 2, 3};
    exp_res = '{8'h99, 8'h00, 8'h26, 8'hFF};
    exp_cyc = '{9, 10, 10, 10};
    for (int t = 0; t < 4; t++) begin
      wait_done(30, idx, cyc, gseen, gcyc);
      chk($sformatf("all_idx%0d", t), 32'(idx), 32'(exp_ord[t]));
      chk($sformatf("all_cyc%0d", t), 32'(cyc), 32'(exp_cyc[t]));
      chk($sformatf("all_res%0d", t), 32'(result), 32'(exp_res[t]));
    end

    // Single request: A5 ^ 3C.
    start(4'b0001);
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_busy", 32'(busy), 32'h1);
    wait_done(30, idx, cyc, gseen, gcyc);
    req = 4'b0000;
    chk("single_idx", 32'(idx), 32'd0);
    chk("single_lat", 32'(cyc), 32'd9);
    chk("single_gnt_cycles", 32'(gcyc + 1), 32'd9);
    chk("single_result", 32'(result), 32'h99);
    chk("single_gnt_off", 32'(gnt), 32'h0);
`ifdef XOR_PARITY_OUT_EN
    chk("single_parity", 32'(parity), 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("single_done_pulse", 32'(done), 32'h0);
    chk("single_busy_idle", 32'(busy), 32'h0);
    chk("single_result_held", 32'(result), 32'h99);

    // Fairness between req0 and req2.
    start(4'b0101);
    exp_ord = '{0, 2, 0, 2};
    exp_res = '{8'h99, 8'h26, 8'h99, 8'h26};
    for (int t = 0; t < 4; t++) begin
      wait_done(30, idx, cyc, gseen, gcyc);
      chk($sformatf("fair_idx%0d", t), 32'(idx), 32'(exp_ord[t]));
      chk($sformatf("fair_res%0d", t), 32'(result), 32'(exp_res[t]));
      chk($sformatf("fair_nogrant13_%0d", t), 32'(gseen & 4'b1010), 32'h0);
    end
    req = 4'b0000;

    // Request dropped after three SHIFT cycles still completes.
    start(4'b0010);
    chk("drop_gnt", 32'(gnt), 32'h2);
    repeat (3) @(posedge clk);
    #1;
    req = 4'b0000;
    wait_done(30, idx, cyc, gseen, gcyc);
    chk("drop_idx", 32'(idx), 32'd1);
    chk("drop_cyc", 32'(cyc), 32'd6);
    chk("drop_result", 32'(result), 32'h00);
`ifdef XOR_PARITY_OUT_EN
    chk("drop_parity", 32'(parity), 32'h0);
`endif

    // Reset at cnt=4 abandons the transaction and clears result.
    start(4'b0001);
    wait_done(30, idx, cyc, gseen, gcyc);
    chk("pre_rst_result", 32'(result), 32'h99);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_result", 32'(result), 32'h0);
    req = 4'b1000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'h8);
    wait_done(30, idx, cyc, gseen, gcyc);
    chk("post_rst_idx", 32'(idx), 32'd3);
    chk("post_rst_cyc", 32'(cyc), 32'd9);
    chk("post_rst_result", 32'(result), 32'hFF);
`ifdef XOR_PARITY_OUT_EN
    chk("post_rst_parity", 32'(parity), 32'h0);
`endif
    req = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
